// File: rtl/nios2_c_sd_dat_rx_pkg.sv
// Shared constants and types for the SD 4-bit data receive engine.
// Optional CRC checking is selected with the SD_DAT_RX_CRC_EN macro.
package nios2_c_sd_dat_rx_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_CONTROL = 3'd2;
  localparam logic [2:0] ADDR_BLKLEN  = 3'd3;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd4;

  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_CRC_ERR   = 2;
  localparam int ST_TIMEOUT   = 3;
  localparam int ST_END_ERR   = 4;
  localparam int ST_LEVEL_LSB = 8;

  localparam int CTL_START  = 0;
  localparam int CTL_ABORT  = 1;
  localparam int CTL_IRQ_EN = 2;

  // x^16 + x^12 + x^5 + 1, x^16 term implicit
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    DATA       = 3'd2,
    CRC        = 3'd3,
    END        = 3'd4,
    DONE       = 3'd5
  } rx_state_t;

endpackage

// File: rtl/nios2_c_sd_dat_rx_crc16.sv
// Bit-serial CRC16 (CCITT polynomial, init 0) for one SD DAT line.
module sd_crc16_serial
  import nios2_c_sd_dat_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;
  assign fb = din ^ crc[15];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  crc <= '0;
    else if (clr)  crc <= '0;
    else if (en)   crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

endmodule

// File: rtl/nios2_c_sd_dat_rx.sv
// SD 4-bit DAT block receiver with Avalon-MM slave and word FIFO.
// Define SD_DAT_RX_CRC_EN to build the per-line CRC16 checkers.
module nios2_c_sd_dat_rx
  import nios2_c_sd_dat_rx_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int BLKLEN_RST = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [3:0]  sd_dat_in,
  output logic        sd_clk_out,
  output logic        irq
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

  rx_state_t   state, state_n;
  logic        running, busy;
  logic [7:0]  div_cnt;
  logic        stall, tick, sample, data_en;
  logic        irq_en, done, crc_err, to_flag, end_err;
  logic [11:0] blklen;
  logic [15:0] tmo_reg, to_cnt;
  logic [12:0] nib_cnt;
  logic [3:0]  crc_cnt;
  logic [31:0] wbuf, word_nx, word_q;
  logic [4:0]  shamt;
  logic        pend, word_done, last_nib, to_hit, crc_mis;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, level;
  logic        full, empty, push, pop, flush;
  logic        wr_en, rd_en, ctl_wr, start_cmd, abort_cmd;
  logic [31:0] lvl32, status_w;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:16];

  // Bus decode; abort dominates start, start only honoured from IDLE
  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & ~read_n;
  assign ctl_wr    = wr_en & (address == ADDR_CONTROL);
  assign abort_cmd = ctl_wr & writedata[CTL_ABORT];
  assign start_cmd = ctl_wr & writedata[CTL_START] & ~writedata[CTL_ABORT] & (state == IDLE);

  // A finished word that cannot enter a full FIFO parks the SD clock low
  assign stall   = pend & full & ~sd_clk_out;
  assign tick    = running & ~stall & (div_cnt == DIV_LAST);
  assign sample  = tick & ~sd_clk_out;
  assign data_en = sample & (state == DATA);

  assign to_hit   = ({1'b0, to_cnt} + 17'd1) >= {1'b0, tmo_reg};
  assign last_nib = nib_cnt == ({blklen, 1'b0} - 13'd1);
  // First nibble of each byte is the high one; bytes fill the word LSB first
  assign shamt     = {nib_cnt[2:1], ~nib_cnt[0], 2'b00};
  assign word_nx   = wbuf | (32'(sd_dat_in) << shamt);
  assign word_done = data_en & ~abort_cmd & ((nib_cnt[2:0] == 3'd7) | last_nib);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    if (abort_cmd) state_n = IDLE;
    else begin
      case (state)
        IDLE:       if (start_cmd) state_n = WAIT_START;
        WAIT_START: if (sample) begin
                      if (sd_dat_in == 4'b0000) state_n = DATA;
                      else if (to_hit)          state_n = DONE;
                    end
        DATA:       if (sample && last_nib)           state_n = CRC;
        CRC:        if (sample && crc_cnt == 4'd15)   state_n = END;
        END:        if (sample)                       state_n = DONE;
        DONE:       state_n = IDLE;
        default:    state_n = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    running = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE:    busy    = 1'b0;
      DONE:    running = 1'b0;
      default: running = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      sd_clk_out <= 1'b0;
    end else if (!running) begin
      div_cnt    <= '0;
      sd_clk_out <= 1'b0;
    end else if (!stall) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt    <= '0;
        sd_clk_out <= ~sd_clk_out;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt  <= '0;
      nib_cnt <= '0;
      crc_cnt <= '0;
      wbuf    <= '0;
      done    <= 1'b0;
      crc_err <= 1'b0;
      to_flag <= 1'b0;
      end_err <= 1'b0;
    end else if (start_cmd) begin
      to_cnt  <= '0;
      nib_cnt <= '0;
      crc_cnt <= '0;
      wbuf    <= '0;
      done    <= 1'b0;
      crc_err <= 1'b0;
      to_flag <= 1'b0;
      end_err <= 1'b0;
    end else if (sample && !abort_cmd) begin
      case (state)
        WAIT_START: if (sd_dat_in != 4'b0000) begin
                      to_cnt <= to_cnt + 16'd1;
                      if (to_hit) to_flag <= 1'b1;
                    end
        DATA: begin
          nib_cnt <= nib_cnt + 13'd1;
          wbuf    <= word_done ? '0 : word_nx;
        end
        CRC: begin
          crc_cnt <= crc_cnt + 4'd1;
          if (crc_mis) crc_err <= 1'b1;
        end
        END: begin
          if (sd_dat_in != 4'b1111) end_err <= 1'b1;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SD_DAT_RX_CRC_EN
  logic [3:0][15:0] crc_q;
  logic [3:0]       crc_bit;
  for (genvar i = 0; i < 4; i++) begin : g_crc
    sd_crc16_serial u_crc (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (start_cmd),
      .en      (data_en),
      .din     (sd_dat_in[i]),
      .crc     (crc_q[i])
    );
    // Engines hold still during CRC, so index the expected bit MSB first
    assign crc_bit[i] = crc_q[i][4'd15 - crc_cnt];
  end
  assign crc_mis = |(crc_bit ^ sd_dat_in);
`else
  assign crc_mis = 1'b0;
`endif

  assign flush = start_cmd | abort_cmd;
  assign level = wptr - rptr;
  assign full  = level == LVL_FULL;
  assign empty = level == '0;
  assign pop   = rd_en & (address == ADDR_DATA) & ~empty;
  assign push  = pend & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend   <= 1'b0;
      word_q <= '0;
    end else if (flush) begin
      pend <= 1'b0;
    end else begin
      if (push) pend <= 1'b0;
      if (word_done) begin
        pend   <= 1'b1;
        word_q <= word_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= word_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en  <= 1'b0;
      blklen  <= 12'(BLKLEN_RST);
      tmo_reg <= 16'hFFFF;
    end else if (wr_en) begin
      case (address)
        ADDR_CONTROL: irq_en  <= writedata[CTL_IRQ_EN];
        ADDR_BLKLEN:  blklen  <= writedata[11:0];
        ADDR_TIMEOUT: tmo_reg <= writedata[15:0];
        default: ;
      endcase
    end
  end

  assign lvl32    = 32'(level);
  assign status_w = {19'b0, lvl32[4:0], 3'b0, end_err, to_flag, crc_err, done, busy};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else if (rd_en) begin
      case (address)
        ADDR_DATA:    readdata <= empty ? 32'h0 : mem[rptr[AW-1:0]];
        ADDR_STATUS:  readdata <= status_w;
        ADDR_CONTROL: readdata <= {29'b0, irq_en, 2'b00};
        ADDR_BLKLEN:  readdata <= {20'b0, blklen};
        ADDR_TIMEOUT: readdata <= {16'b0, tmo_reg};
        default:      readdata <= '0;
      endcase
    end
  end

  assign irq = irq_en & (done | to_flag);

endmodule

// File: tb/tb_nios2_c_sd_dat_rx.sv
// Bench for nios2_c_sd_dat_rx: card model streams nibbles on SD clock falls,
// expectations come from byte packing and CRC16 long division of the block.
module tb_nios2_c_sd_dat_rx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int BLKLEN_RST = 512;
`ifdef SD_DAT_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  sd_dat_in;
  logic        sd_clk_out;
  logic        irq;

  always #5 clk = ~clk;

  nios2_c_sd_dat_rx #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .BLKLEN_RST(BLKLEN_RST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .sd_dat_in(sd_dat_in), .sd_clk_out(sd_clk_out), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  // Card: stream[k] is on the bus for the (k+1)-th SD clock rise after loading
  logic [3:0]  stream [0:2047];
  logic [3:0]  nib    [0:1023];
  logic [31:0] expw   [0:127];
  logic [16:0] poly17 = 17'h11021;
  int slen = 0, sbase = 0, falls = 0, rises = 0, sidx;

  always @(negedge sd_clk_out) falls = falls + 1;
  always @(posedge sd_clk_out) rises = rises + 1;
  assign sidx      = falls - sbase;
  assign sd_dat_in = (sidx >= 0 && sidx < slen) ? stream[sidx[10:0]] : 4'hF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk); address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk); address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk); chipselect = 1'b0; read_n = 1'b1; v = readdata;
  endtask

  task automatic wait_idle(input string tag, input int bound, output logic [31:0] st);
    int n = 0;
    rd(3'd1, st);
    while (st[0] && n < bound) begin rd(3'd1, st); n++; end
    chk({tag, "_idle"}, 32'(st[0]), 32'd0);
  endtask

  // Expected words and the full line stream (start, data, per-line CRC, end)
  task automatic build(input int blen, input int fl_line, input int fl_pos);
    int n;
    bit r [0:1100];
    n = 2 * blen;
    for (int k = 0; k < 128; k++) expw[k] = '0;
    for (int b = 0; b < blen; b++)
      expw[b/4] = expw[b/4] | ({24'b0, nib[2*b], nib[2*b+1]} << (8 * (b % 4)));
    stream[0] = 4'hF;
    stream[1] = 4'h0;
    for (int k = 0; k < n; k++) stream[2+k] = nib[k];
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < n + 16; k++) r[k] = (k < n) ? nib[k][i] : 1'b0;
      for (int k = 0; k < n; k++)
        if (r[k]) for (int t = 0; t <= 16; t++) r[k+t] = r[k+t] ^ poly17[16-t];
      for (int j = 0; j < 16; j++) stream[2+n+j][i] = r[n+j];
    end
    if (fl_line >= 0) stream[2+n+fl_pos][fl_line] = ~stream[2+n+fl_pos][fl_line];
    stream[2+n+16] = 4'hF;
    sbase = falls;
    slen  = n + 19;
  endtask

  task automatic run_xfer(input string tag, input int blen, input bit crc_bad);
    logic [31:0] st, d;
    int nw;
    nw = (blen + 3) / 4;
    wr(3'd3, 32'(blen));
    wr(3'd2, 32'h5);
    wait_idle(tag, 2000, st);
    chk({tag, "_done"},    32'(st[1]), 32'd1);
    chk({tag, "_crc_err"}, 32'(st[2]), 32'(crc_bad && CRC_ON));
    chk({tag, "_tmo"},     32'(st[3]), 32'd0);
    chk({tag, "_end_err"}, 32'(st[4]), 32'd0);
    chk({tag, "_level"},   32'(st[12:8]), 32'(nw));
    chk({tag, "_irq"},     32'(irq), 32'd1);
    for (int k = 0; k < nw; k++) begin
      rd(3'd0, d);
      chk($sformatf("%s_w%0d", tag, k), d, expw[k]);
    end
    rd(3'd1, st);
    chk({tag, "_drained"}, 32'(st[12:8]), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st, d;
    int n, idx, r0;

    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_sdclk", 32'(sd_clk_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    rd(3'd1, st); chk("rst_status", st, 32'd0);
    rd(3'd3, st); chk("rst_blklen", st, 32'(BLKLEN_RST));
    rd(3'd4, st); chk("rst_timeout", st, 32'h0000FFFF);
    rd(3'd2, st); chk("rst_control", st, 32'd0);
    rd(3'd0, st); chk("rst_empty_data", st, 32'd0);

    // Counting nibbles 1..F,0
    for (int k = 0; k < 16; k++) nib[k] = 4'((k + 1) % 16);
    build(8, -1, 0);
    run_xfer("t1", 8, 1'b0);

    // Same block, line 2 CRC bit 5 corrupted
    build(8, 2, 5);
    run_xfer("t2", 8, 1'b1);

    // Random blocks, including lengths that pad the last word
    for (int k = 0; k < 44; k++) nib[k] = 4'($urandom);
    build(22, -1, 0);
    run_xfer("t3", 22, 1'b0);
    for (int k = 0; k < 4; k++) nib[k] = 4'($urandom);
    build(2, -1, 0);
    run_xfer("t4", 2, 1'b0);

    // Timeout: no start bit ever
    wr(3'd4, 32'd10);
    sbase = falls; slen = 0; r0 = rises;
    wr(3'd2, 32'h5);
    wait_idle("tmo", 500, st);
    chk("tmo_flag",  32'(st[3]), 32'd1);
    chk("tmo_level", 32'(st[12:8]), 32'd0);
    chk("tmo_clocks", 32'(rises - r0), 32'd10);
    chk("tmo_irq",   32'(irq), 32'd1);
    wr(3'd4, 32'h0000FFFF);

    // Flow control: 512-byte block with a stalled reader
    for (int k = 0; k < 1024; k++) nib[k] = 4'($urandom);
    build(512, -1, 0);
    wr(3'd3, 32'd512);
    wr(3'd2, 32'h1);
    n = 0; rd(3'd1, st);
    while (st[12:8] != 5'd16 && n < 3000) begin rd(3'd1, st); n++; end
    chk("stall_fill", 32'(st[12:8]), 32'd16);
    repeat (200) @(negedge clk);
    n = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); n += int'(sd_clk_out); end
    chk("stall_clk_low", 32'(n), 32'd0);
    rd(3'd1, st); chk("stall_level", 32'(st[12:8]), 32'd16);
    rd(3'd0, d);  chk("stall_w0", d, expw[0]);
    n = 0;
    while (!sd_clk_out && n <= CLK_DIV + 1) begin @(negedge clk); n++; end
    chk("stall_resume", 32'(sd_clk_out && n <= CLK_DIV + 1), 32'd1);
    idx = 1; n = 0;
    while (idx < 128 && n < 20000) begin
      rd(3'd1, st);
      if (st[12:8] != 5'd0) begin
        rd(3'd0, d);
        chk($sformatf("stall_w%0d", idx), d, expw[idx]);
        idx++;
      end
      n++;
    end
    chk("stall_word_count", 32'(idx), 32'd128);
    wait_idle("stall", 500, st);
    chk("stall_done", 32'(st[1]), 32'd1);
    chk("stall_crc_err", 32'(st[2]), 32'd0);

    // Abort mid-DATA once three words are queued
    for (int k = 0; k < 128; k++) nib[k] = 4'($urandom);
    build(64, -1, 0);
    wr(3'd3, 32'd64);
    wr(3'd2, 32'h1);
    n = 0; rd(3'd1, st);
    while (st[12:8] < 5'd3 && n < 2000) begin rd(3'd1, st); n++; end
    chk("abort_fill", 32'(st[12:8]), 32'd3);
    wr(3'd2, 32'h2);
    rd(3'd1, st);
    chk("abort_busy",  32'(st[0]), 32'd0);
    chk("abort_done",  32'(st[1]), 32'd0);
    chk("abort_level", 32'(st[12:8]), 32'd0);
    chk("abort_sdclk", 32'(sd_clk_out), 32'd0);
    rd(3'd0, d); chk("abort_data_empty", d, 32'd0);

    // Reset during CRC phase while sd_clk is high
    for (int k = 0; k < 16; k++) nib[k] = 4'($urandom);
    build(8, -1, 0);
    wr(3'd3, 32'd8);
    r0 = rises;
    wr(3'd2, 32'h5);
    n = 0; rd(3'd1, st);
    while (!((rises - r0) >= 22 && sd_clk_out) && n < 500) begin rd(3'd1, st); n++; end
    chk("rstmid_reached", 32'(sd_clk_out && (rises - r0) >= 22 && (rises - r0) < 34), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_readdata", readdata, 32'd0);
    chk("rstmid_sdclk", 32'(sd_clk_out), 32'd0);
    chk("rstmid_irq", 32'(irq), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    rd(3'd1, st); chk("rstmid_status", st, 32'd0);
    rd(3'd3, st); chk("rstmid_blklen", st, 32'(BLKLEN_RST));
    for (int k = 0; k < 16; k++) nib[k] = 4'($urandom);
    build(8, -1, 0);
    run_xfer("t_post_rst", 8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios2_c_sd_dat_rx.md
Name: nios2_c_sd_dat_rx

Overview:
- Hardware receive engine for the SD card 4-bit data bus. Replaces CPU bit-banging of DAT[3:0] for block reads.
- Generates the SD clock, waits for the start bit, and shifts in one data block nibble-wise. Checks per-line CRC16 and packs bytes into 32-bit words in a small FIFO that Nios II drains over an Avalon-MM slave.
- Sits between the SD DAT pins (input side) and the CPU data master.

Parameters:
- CLK_DIV, 4, sd_clk half-period in clk cycles; legal range 1..255.
- FIFO_DEPTH, 16, receive FIFO depth in 32-bit words; power of 2, at least 4.
- BLKLEN_RST, 512, reset value of the BLKLEN register in bytes.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  async active-low reset.
- address  in  3  register select.
- chipselect  in  1  Avalon slave select.
- read_n  in  1  Avalon read strobe, active-low.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  read data, registered, 1-cycle latency.
- sd_dat_in  in  4  DAT[3:0] from pads, synchronised externally.
- sd_clk_out  out  1  SD clock to card.
- irq  out  1  level interrupt.

Behaviour:
- Reset is decided: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: readdata=0, sd_clk_out=0, irq=0, state IDLE, FIFO empty, all flags 0, BLKLEN=BLKLEN_RST, TIMEOUT=0xFFFF, irq_en=0.
- Register map:
  - 0 DATA (R): pops FIFO. Reads 0 with no pop when the FIFO is empty.
  - 1 STATUS (R): bit0 busy, bit1 done, bit2 crc_err, bit3 timeout, bit4 end_err, bits[12:8] fifo_level.
  - 2 CONTROL (W): bit0 start, bit1 abort, bit2 irq_en. Reads back irq_en in bit2.
  - 3 BLKLEN (R/W): bits[11:0], bytes per block, even values 2..2048.
  - 4 TIMEOUT (R/W): bits[15:0], SD clocks to wait for the start bit.
- A pop occurs in the cycle where chipselect & ~read_n & address==0. Data appears on readdata the next cycle.
- SD clock:
  - Divider toggles sd_clk_out every CLK_DIV clk cycles while state is not IDLE or DONE.
  - Sample point is the clk cycle in which sd_clk_out goes 0->1.
  - sd_clk_out is held low in IDLE and DONE.
- Flow control: if the FIFO is full and a word is pending, the divider freezes with sd_clk_out low. It resumes the cycle after a pop.
- FSM transitions (on sample points):
  - IDLE -> WAIT_START on a start write. Start clears flags, flushes the FIFO and clears the timeout counter.
  - WAIT_START: sd_dat_in==4'b0000 -> DATA. If the SD clock count reaches TIMEOUT -> DONE with timeout=1.
  - DATA: each sample shifts one nibble; the first nibble of a byte is the high nibble. Bytes pack little-endian: the first byte goes to bits[7:0]. A full word is pushed to the FIFO. After BLKLEN*2 nibbles -> CRC.
  - CRC: 16 samples. Line i bit is compared to line i's CRC16 (poly x^16+x^12+x^5+1, init 0), MSB first. Any mismatch sets crc_err. Then -> END.
  - END: one sample; anything other than 4'b1111 sets end_err. Then -> DONE with done=1.
  - DONE -> IDLE the next clk cycle; flags persist until the next start.
- A BLKLEN not a multiple of 4 pads the final word with zeros in the upper bytes. That word is pushed at the end of DATA.
- Start while busy is ignored.
- Abort in any state:
  - State goes to IDLE and the FIFO is flushed.
  - Flags are not set and done is not set.
  - Abort wins over start in the same write.
- Simultaneous push and pop: both take effect and the level is unchanged.
- irq = irq_en & (done | timeout), level.
- Reset mid-transfer returns everything to reset values immediately.

Optional Feature:
- Macro: SD_DAT_RX_CRC_EN.
- Defined: the four CRC16 engines are instantiated and crc_err behaves as above.
- Undefined: no CRC logic is built. The CRC state still consumes 16 samples, and crc_err reads 0.

Decomposition:
- Package nios2_c_sd_dat_rx_pkg holds:
  - register address constants;
  - STATUS/CONTROL bit positions;
  - the FSM state typedef (IDLE, WAIT_START, DATA, CRC, END, DONE);
  - the CRC16 polynomial constant.
- Sub-module sd_crc16_serial: 1-bit serial CRC16 with clear and enable, instantiated once per DAT line.
- The FIFO is kept inline.

Test Plan:
- BLKLEN=8, card sends start, then nibbles 1,2,3,4,5,6,7,8,9,A,B,C,D,E,F,0, correct CRCs, end 1111 -> DATA reads 0x78563412 then 0xF0DEBC9A; STATUS done=1, crc_err=0; irq=1 with irq_en=1.
- Same block with line 2 CRC bit 5 flipped -> crc_err=1, done=1, data words unchanged.
- TIMEOUT=10, lines held 1111 -> after 10 SD clocks STATUS timeout=1, busy=0, FIFO empty.
- BLKLEN=512, FIFO_DEPTH=16, no CPU reads -> sd_clk_out stops low with fifo_level=16. After one DATA read, clocking resumes within CLK_DIV+1 cycles. All 128 words are read back in order.
- Abort mid-DATA after 3 words pushed -> state IDLE, fifo_level=0, done=0, sd_clk_out=0.
- reset_n low mid-CRC -> all outputs at reset values the same cycle; a subsequent start runs normally.
